// File: rtl/pipe_pkg.sv
// Shared widths, saturation constant and result record for the
// series-evaluation pipeline.
package pipe_pkg;

   localparam int Y_W = 32;
   localparam int X_W = 8;
   localparam int N_W = 4;

   localparam logic [Y_W-1:0] SAT_Y = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [Y_W-1:0] y;
      logic [X_W-1:0] x;
      logic           ovf;
   } result_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two,
// so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 8,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; the count qualifies every read.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/result_collector_pipe.sv
// Terminal pipeline stage: buffers results in a FIFO and hands out issue
// credits. Define COLLECTOR_SAT_EN to store overflowed results as SAT_Y.
module result_collector_pipe
   import pipe_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           init,
   input  logic [Y_W-1:0] inp_y,
   input  logic [X_W-1:0] inp_x,
   input  logic           inp_ovf,
   input  logic           inp_valid,
   input  logic           issue,
   output logic           credit_ok,
   output logic [Y_W-1:0] res_y,
   output logic [X_W-1:0] res_x,
   output logic           res_ovf,
   output logic           res_valid,
   input  logic           res_ready,
   output logic           err_drop
);

   logic          clr;
   logic          push;
   logic          pop;
   logic          drop;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic [CW-1:0] cred;
   result_t       wr_ent;
   result_t       head;

   assign clr  = rst | init;
   assign pop  = res_valid & res_ready;
   // A full FIFO still accepts a result when the head leaves in the same cycle.
   assign push = inp_valid & (~full | pop);
   assign drop = inp_valid & full & ~pop;

   always_comb begin
      wr_ent.x   = inp_x;
      wr_ent.ovf = inp_ovf;
`ifdef COLLECTOR_SAT_EN
      wr_ent.y   = inp_ovf ? SAT_Y : inp_y;
`else
      wr_ent.y   = inp_y;
`endif
   end

   sync_fifo #(
      .WIDTH ($bits(result_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (clr),
      .push  (push),
      .pop   (pop),
      .wdata (wr_ent),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign res_valid = ~empty;
   assign res_y     = res_valid ? head.y   : '0;
   assign res_x     = res_valid ? head.x   : '0;
   assign res_ovf   = res_valid ? head.ovf : 1'b0;

   // Issue at zero credits holds at zero; a stray pop never lifts past DEPTH.
   always_ff @(posedge clk) begin
      if (clr) begin
         cred <= CW'(DEPTH);
      end else if (issue && !pop) begin
         if (cred != '0) cred <= cred - CW'(1);
      end else if (pop && !issue) begin
         if (cred != CW'(DEPTH)) cred <= cred + CW'(1);
      end
   end

   assign credit_ok = (cred != '0);

   always_ff @(posedge clk) begin
      if (clr)       err_drop <= 1'b0;
      else if (drop) err_drop <= 1'b1;
   end

endmodule

// File: tb/tb_result_collector_pipe.sv
// Directed bench for result_collector_pipe: reset, single result, fill/drain,
// drop, simultaneous events at full, saturation and mid-operation reset.
module tb_result_collector_pipe;
   import pipe_pkg::*;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           init = 1'b0;
   logic [Y_W-1:0] inp_y = '0;
   logic [X_W-1:0] inp_x = '0;
   logic           inp_ovf = 1'b0;
   logic           inp_valid = 1'b0;
   logic           issue = 1'b0;
   logic           credit_ok;
   logic [Y_W-1:0] res_y;
   logic [X_W-1:0] res_x;
   logic           res_ovf;
   logic           res_valid;
   logic           res_ready = 1'b0;
   logic           err_drop;

   int n_cmp = 0;
   int n_bad = 0;

   result_collector_pipe #(.DEPTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .init      (init),
      .inp_y     (inp_y),
      .inp_x     (inp_x),
      .inp_ovf   (inp_ovf),
      .inp_valid (inp_valid),
      .issue     (issue),
      .credit_ok (credit_ok),
      .res_y     (res_y),
      .res_x     (res_x),
      .res_ovf   (res_ovf),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .err_drop  (err_drop)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push1(input logic [31:0] y, input logic [7:0] x, input logic ovf);
      inp_valid = 1'b1; inp_y = y; inp_x = x; inp_ovf = ovf;
      step();
      inp_valid = 1'b0;
   endtask

   task automatic pulse_init();
      init = 1'b1;
      step();
      init = 1'b0;
   endtask

   initial begin
      logic [31:0] sat_exp;
`ifdef COLLECTOR_SAT_EN
      sat_exp = 32'hFFFF_FFFF;
`else
      sat_exp = 32'h1234_5678;
`endif
      // Reset state
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      chk("rst_valid", {31'd0, res_valid}, 0);
      chk("rst_credit", {31'd0, credit_ok}, 1);
      chk("rst_drop", {31'd0, err_drop}, 0);
      chk("rst_y", res_y, 0);

      // Eight issues exhaust the credits
      issue = 1'b1;
      for (int i = 0; i < 7; i++) step();
      chk("credit_after7", {31'd0, credit_ok}, 1);
      step();
      chk("credit_after8", {31'd0, credit_ok}, 0);
      step();  // protocol error: issue at zero must hold
      issue = 1'b0;
      chk("credit_hold0", {31'd0, credit_ok}, 0);

      // Single result, held stable under backpressure
      push1(32'h0001_2345, 8'h05, 1'b0);
      chk("single_valid", {31'd0, res_valid}, 1);
      chk("single_y", res_y, 32'h0001_2345);
      chk("single_x", {24'd0, res_x}, 32'h05);
      chk("single_ovf", {31'd0, res_ovf}, 0);
      chk("single_credit_pre", {31'd0, credit_ok}, 0);
      step();
      chk("single_stable_y", res_y, 32'h0001_2345);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("single_popped", {31'd0, res_valid}, 0);
      chk("single_zero_y", res_y, 0);
      chk("single_credit_inc", {31'd0, credit_ok}, 1);
      issue = 1'b1;
      step();
      issue = 1'b0;
      chk("single_credit_dec", {31'd0, credit_ok}, 0);
      pulse_init();
      chk("init_credit", {31'd0, credit_ok}, 1);

      // Fill, overflow drop, drain in order
      for (int i = 0; i < 8; i++) push1(32'h100 + 32'(i), 8'(i), 1'b0);
      chk("fill_drop_clear", {31'd0, err_drop}, 0);
      push1(32'hDEAD_BEEF, 8'hAA, 1'b0);
      chk("drop_set", {31'd0, err_drop}, 1);
      res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_x%0d", i), {24'd0, res_x}, 32'(i));
         chk($sformatf("drain_y%0d", i), res_y, 32'h100 + 32'(i));
         step();
      end
      res_ready = 1'b0;
      chk("drain_empty", {31'd0, res_valid}, 0);
      chk("drop_sticky", {31'd0, err_drop}, 1);
      pulse_init();
      chk("drop_cleared", {31'd0, err_drop}, 0);

      // Simultaneous push+pop and issue+pop at full
      issue = 1'b1;
      for (int i = 0; i < 8; i++) step();
      issue = 1'b0;
      for (int i = 0; i < 8; i++) push1(32'h200 + 32'(i), 8'h10 + 8'(i), 1'b0);
      chk("full_credit0", {31'd0, credit_ok}, 0);
      inp_valid = 1'b1; inp_y = 32'h0000_0220; inp_x = 8'h20; inp_ovf = 1'b0;
      res_ready = 1'b1; issue = 1'b1;
      step();
      inp_valid = 1'b0; issue = 1'b0;
      chk("simul_credit", {31'd0, credit_ok}, 0);
      chk("simul_nodrop", {31'd0, err_drop}, 0);
      chk("simul_head", {24'd0, res_x}, 32'h11);
      step();  // pop alone
      chk("pop_credit", {31'd0, credit_ok}, 1);
      for (int i = 2; i < 8; i++) begin
         chk($sformatf("simul_drain%0d", i), {24'd0, res_x}, 32'h10 + 32'(i));
         step();
      end
      chk("simul_tail_x", {24'd0, res_x}, 32'h20);
      chk("simul_tail_y", res_y, 32'h220);
      step();
      res_ready = 1'b0;
      chk("simul_empty", {31'd0, res_valid}, 0);

      // Saturation
      pulse_init();
      push1(32'h1234_5678, 8'h03, 1'b1);
      chk("sat_y", res_y, sat_exp);
      chk("sat_ovf", {31'd0, res_ovf}, 1);
      chk("sat_x", {24'd0, res_x}, 32'h03);

      // Reset mid-operation discards everything
      push1(32'h55, 8'h55, 1'b0);
      issue = 1'b1;
      step();
      issue = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_valid", {31'd0, res_valid}, 0);
      chk("midrst_x", {24'd0, res_x}, 0);
      chk("midrst_credit", {31'd0, credit_ok}, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
